uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The parameter list SHALL be: ACK_TO, 4, max cycles in ACK_WAIT for xmit_doneH to fall.
REQ-002 The parameter list SHALL also contain: DONE_TO, 16'd4095, max cycles in DONE_WAIT for xmit_doneH to rise.
REQ-003 The ports SHALL be, in order:
 - sys_clk  in  1  clock, rising edge.
 - sys_rst_l  in  1  reset, asynchronous, active-low.
 - req  in  4  per-requester level request.
 - req_data  in  32  byte for requester i at bits [8i+7:8i].
 - gnt  out  4  one-hot, one-cycle accept pulse.
 - xmitH  out  1  transmit strobe to the UART transmitter.
 - xmit_dataH  out  8  byte to the transmitter.
 - xmit_doneH  in  1  transmitter idle/done level.
 - busy  out  1  high whenever state is not IDLE.
 - timeout_err  out  1  sticky handshake-failure flag.
 - err_clr  in  1  synchronous clear of timeout_err.

Function
REQ-004 All outputs SHALL be registered; the state machine SHALL have exactly four states: IDLE, LAUNCH, ACK_WAIT, DONE_WAIT.
REQ-005 IDLE, with |req==1 and xmit_doneH==1 at edge N: the block SHALL at edge N+1 enter LAUNCH with xmitH=1, gnt=one-hot winner, xmit_dataH=winner's byte.
REQ-006 IDLE with xmit_doneH==0 SHALL stay in IDLE with no grant, regardless of req.
REQ-007 Arbitration SHALL be round-robin: search starts at (last_winner+1) mod 4 and ascends with wrap; last_winner resets to 3, so requester 0 has first priority after reset.
REQ-008 last_winner SHALL update at the grant edge only.
REQ-009 gnt and xmitH SHALL each be high for exactly one cycle per transfer, and at most one gnt bit SHALL ever be high.
REQ-010 xmit_dataH SHALL hold its value from grant until the next grant.
REQ-011 Requesters SHALL hold req and data stable until gnt; a req dropped before gnt is withdrawn with no side effect.
REQ-012 LAUNCH SHALL unconditionally go to ACK_WAIT on the next edge, with xmitH=0.
REQ-013 ACK_WAIT: xmit_doneH==0 SHALL go to DONE_WAIT.
REQ-014 ACK_WAIT: after ACK_TO consecutive cycles with xmit_doneH==1, the block SHALL set timeout_err and return to IDLE.
REQ-015 DONE_WAIT: xmit_doneH==1 SHALL return to IDLE; the earliest next grant is on the following edge.
REQ-016 DONE_WAIT: after DONE_TO cycles without xmit_doneH rising, the block SHALL set timeout_err and return to IDLE.
REQ-017 A single 16-bit wait counter SHALL clear on entry to ACK_WAIT and DONE_WAIT, increment while waiting, and never wrap.
REQ-018 err_clr SHALL clear timeout_err on the next edge; if err_clr and a new timeout occur in the same cycle, set SHALL win.
REQ-019 timeout_err SHALL NOT block further arbitration.
REQ-020 busy SHALL be 1 in LAUNCH, ACK_WAIT and DONE_WAIT and 0 in IDLE.

Reset
REQ-021 Asserting sys_rst_l=0 SHALL immediately, including mid-transfer, force: state=IDLE, gnt=0, xmitH=0, xmit_dataH=8'h00, busy=0, timeout_err=0, counter=0, last_winner=3.
REQ-022 After reset release, the first grant SHALL occur no earlier than the first edge with req and xmit_doneH both high.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
 - Single transfer: req=4'b0100, byte2=8'hA5, done model drops 2 cycles after xmitH and rises 20 cycles later -> gnt=4'b0100 for 1 cycle, xmitH for 1 cycle, xmit_dataH=8'hA5, busy for 23 cycles, then IDLE.
 - Fairness: req=4'b1111 held, constant done model -> gnt sequence 0001, 0010, 0100, 1000, 0001, with no requester granted twice while another waits.
 - Ack timeout: xmit_doneH tied to 1 -> after grant, timeout_err=1 exactly ACK_TO cycles into ACK_WAIT, return to IDLE, and the next requester is granted.
 - Done timeout: xmit_doneH stuck 0 after the drop -> timeout_err set after 4095 cycles; err_clr pulse clears it; simultaneous err_clr and timeout leaves it at 1.
 - Reset mid-transfer: sys_rst_l pulsed low in DONE_WAIT -> outputs at reset values asynchronously; after release with req=4'b1000, requester 3 is granted first.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that funnels four byte requesters into one UART transmitter over the xmitH/xmit_doneH handshake.
// Grant lands one edge after a request seen in IDLE; stalled handshakes are bounded by ACK_TO/DONE_TO and flagged in timeout_err.
module uart_tx_arb #(
  parameter int          ACK_TO  = 4,
  parameter logic [15:0] DONE_TO = 16'd4095
) (
  input  logic        sys_clk,
  input  logic        sys_rst_l,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic        xmitH,
  output logic [7:0]  xmit_dataH,
  input  logic        xmit_doneH,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, LAUNCH, ACK_WAIT, DONE_WAIT} state_t;

  localparam logic [15:0] ACK_LIM  = 16'(ACK_TO - 1);
  localparam logic [15:0] DONE_LIM = DONE_TO - 16'd1;

  state_t      state, stateNxt;
  logic [15:0] waitCnt, waitCntNxt;
  logic [1:0]  lastWinner, lastWinnerNxt;
  logic [1:0]  winIdx;
  logic        winFound;
  logic [3:0]  gntNxt;
  logic        xmitNxt;
  logic [7:0]  dataNxt;
  logic        busyNxt;
  logic        errNxt;

  // Search starts one past the previous winner; k=4 wraps back to the previous winner itself.
  always_comb begin
    winFound = 1'b0;
    winIdx   = lastWinner;
    for (int k = 1; k <= 4; k++) begin
      if (!winFound && req[lastWinner + 2'(k)]) begin
        winFound = 1'b1;
        winIdx   = lastWinner + 2'(k);
      end
    end
  end

  always_comb begin
    stateNxt      = state;
    waitCntNxt    = waitCnt;
    lastWinnerNxt = lastWinner;
    gntNxt        = 4'b0000;
    xmitNxt       = 1'b0;
    dataNxt       = xmit_dataH;
    errNxt        = timeout_err & ~err_clr;

    case (state)
      IDLE: begin
        if (xmit_doneH && winFound) begin
          stateNxt      = LAUNCH;
          gntNxt        = 4'b0001 << winIdx;
          xmitNxt       = 1'b1;
          dataNxt       = req_data[{winIdx, 3'b000} +: 8];
          lastWinnerNxt = winIdx;
        end
      end
      LAUNCH: begin
        stateNxt   = ACK_WAIT;
        waitCntNxt = 16'd0;
      end
      ACK_WAIT: begin
        if (!xmit_doneH) begin
          stateNxt   = DONE_WAIT;
          waitCntNxt = 16'd0;
        end else if (waitCnt >= ACK_LIM) begin
          errNxt   = 1'b1;
          stateNxt = IDLE;
        end else begin
          waitCntNxt = waitCnt + 16'd1;
        end
      end
      DONE_WAIT: begin
        if (xmit_doneH) begin
          stateNxt = IDLE;
        end else if (waitCnt >= DONE_LIM) begin
          errNxt   = 1'b1;
          stateNxt = IDLE;
        end else begin
          waitCntNxt = waitCnt + 16'd1;
        end
      end
      default: stateNxt = IDLE;
    endcase

    busyNxt = (stateNxt != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state       <= IDLE;
      waitCnt     <= 16'd0;
      lastWinner  <= 2'd3;
      gnt         <= 4'b0000;
      xmitH       <= 1'b0;
      xmit_dataH  <= 8'h00;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= stateNxt;
      waitCnt     <= waitCntNxt;
      lastWinner  <= lastWinnerNxt;
      gnt         <= gntNxt;
      xmitH       <= xmitNxt;
      xmit_dataH  <= dataNxt;
      busy        <= busyNxt;
      timeout_err <= errNxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboarded bench: a round-robin reference model predicts the grant order per request batch,
// a monitor checks every grant against it, and a transmitter model answers the xmitH handshake.
module tb_uart_tx_arb;

  localparam int          ACK_TO  = 4;
  localparam logic [15:0] DONE_TO = 16'd4095;
  localparam int M_NORMAL = 0, M_ACKTO = 1, M_STUCK = 2, M_RELEASE = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst_l;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        xmitH;
  logic [7:0]  xmit_dataH;
  logic        xmit_doneH;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] expQ[$];
  int          mLast;
  bit          holdReq;
  int          doneMode, dropDly, lowLen;

  uart_tx_arb #(.ACK_TO(ACK_TO), .DONE_TO(DONE_TO)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Requesters drop their request on the cycle their grant is seen, unless told to hold it.
  task automatic tick();
    @(negedge sys_clk);
    if (!holdReq) req = req & ~gnt;
  endtask

  // Reference arbiter: n grants in round-robin order from one past the last winner.
  function automatic void pushGrants(input logic [3:0] mask, input int n);
    logic [3:0] m;
    int i;
    m = mask;
    for (int k = 0; k < n; k++) begin
      for (int s = 1; s <= 4; s++) begin
        i = (mLast + s) % 4;
        if (m[i]) begin
          expQ.push_back({4'(1 << i), req_data[8*i +: 8]});
          mLast = i;
          if (!holdReq) m[i] = 1'b0;
          break;
        end
      end
    end
  endfunction

  task automatic waitGnt(input string name, input int maxCyc);
    int n;
    n = 0;
    while (gnt == 4'b0000 && n < maxCyc) begin
      tick();
      n++;
    end
    if (gnt == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within %0d cycles", name, maxCyc);
    end
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((expQ.size() != 0 || busy) && n < maxCyc);
    if (expQ.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL %s: busy=%0b with %0d grants outstanding after %0d cycles, expected idle and none",
               name, busy, expQ.size(), maxCyc);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_xmitH"}, 32'(xmitH), 32'd0);
    check({tag, "_data"}, 32'(xmit_dataH), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Transmitter model: drops done dropDly cycles after seeing xmitH, raises it lowLen cycles later.
  initial begin : doneModel
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    xmit_doneH = 1'b1;
    forever begin
      @(negedge sys_clk);
      case (phase)
        0: if (xmitH && doneMode != M_ACKTO) begin
          if (dropDly == 0) begin
            xmit_doneH = 1'b0;
            phase = 2;
            cnt = lowLen;
          end else begin
            phase = 1;
            cnt = dropDly;
          end
        end
        1: begin
          cnt--;
          if (cnt == 0) begin
            xmit_doneH = 1'b0;
            phase = 2;
            cnt = lowLen;
          end
        end
        default: begin
          if (doneMode == M_RELEASE) begin
            xmit_doneH = 1'b1;
            phase = 0;
          end else if (doneMode != M_STUCK) begin
            cnt--;
            if (cnt == 0) begin
              xmit_doneH = 1'b1;
              phase = 0;
            end
          end
        end
      endcase
    end
  end

  initial begin : monitor
    logic [11:0] e;
    logic [7:0]  lastData;
    bit          prevGnt;
    lastData = 8'h00;
    prevGnt = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_l) begin
        lastData = 8'h00;
        prevGnt = 1'b0;
      end else begin
        check("xmitH_with_gnt", 32'(xmitH), 32'(gnt != 4'b0000));
        if (prevGnt) check("gnt_one_cycle", 32'(gnt), 32'd0);
        if (gnt != 4'b0000) begin
          check("gnt_onehot", 32'($countones(gnt)), 32'd1);
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got gnt=%b, expected no grant", gnt);
          end else begin
            e = expQ.pop_front();
            check("gnt_order", 32'(gnt), 32'(e[11:8]));
            check("grant_data", 32'(xmit_dataH), 32'(e[7:0]));
            lastData = e[7:0];
          end
        end else begin
          check("data_hold", 32'(xmit_dataH), 32'(lastData));
        end
        prevGnt = (gnt != 4'b0000);
      end
    end
  end

  initial begin : stim
    int          busyCnt;
    logic [3:0]  mask;
    bit          expErr;
    sys_rst_l = 1'b0;
    req = 4'b0000;
    req_data = 32'd0;
    err_clr = 1'b0;
    holdReq = 1'b0;
    doneMode = M_NORMAL;
    dropDly = 0;
    lowLen = 2;
    mLast = 3;

    #12;
    checkResetOutputs("reset");
    tick();
    tick();
    sys_rst_l = 1'b1;
    repeat (3) tick();
    check("idle_no_req_busy", 32'(busy), 32'd0);

    // Fairness with all four requests held.
    holdReq = 1'b1;
    req_data = $urandom;
    pushGrants(4'b1111, 5);
    req = 4'b1111;
    busyCnt = 0;
    while (expQ.size() != 0 && busyCnt < 200) begin
      tick();
      busyCnt++;
    end
    req = 4'b0000;
    holdReq = 1'b0;
    waitIdle("fairness", 200);

    // Single transfer, busy length from the done timing.
    dropDly = 2;
    lowLen = 20;
    req_data = {8'h11, 8'hA5, 8'h22, 8'h33};
    pushGrants(4'b0100, 1);
    req = 4'b0100;
    waitGnt("single_grant", 20);
    check("single_data", 32'(xmit_dataH), 32'hA5);
    busyCnt = 0;
    while (busy && busyCnt < 100) begin
      busyCnt++;
      tick();
    end
    check("single_busy_cycles", 32'(busyCnt), 32'd23);
    waitIdle("single_idle", 50);

    // Ack timeout: done never falls.
    doneMode = M_ACKTO;
    req_data = $urandom;
    pushGrants(4'b0011, 2);
    req = 4'b0011;
    waitGnt("ackto_grant", 20);
    repeat (ACK_TO) tick();
    check("ackto_err_before", 32'(timeout_err), 32'd0);
    check("ackto_busy_before", 32'(busy), 32'd1);
    tick();
    check("ackto_err_set", 32'(timeout_err), 32'd1);
    check("ackto_back_idle", 32'(busy), 32'd0);
    waitIdle("ackto_next_requester", 100);
    check("ackto_err_sticky", 32'(timeout_err), 32'd1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 32'(timeout_err), 32'd0);

    // Done timeout: done falls and never rises.
    doneMode = M_STUCK;
    dropDly = 2;
    req_data = $urandom;
    pushGrants(4'b1000, 1);
    req = 4'b1000;
    waitGnt("doneto_grant", 20);
    repeat (int'(DONE_TO) + 2) tick();
    check("doneto_err_before", 32'(timeout_err), 32'd0);
    check("doneto_busy_before", 32'(busy), 32'd1);
    tick();
    check("doneto_err_set", 32'(timeout_err), 32'd1);
    check("doneto_back_idle", 32'(busy), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("doneto_err_clr", 32'(timeout_err), 32'd0);

    // Transmitter not done while idle: request must wait.
    req_data = $urandom;
    pushGrants(4'b0001, 1);
    req = 4'b0001;
    repeat (8) begin
      tick();
      check("done_low_no_gnt", 32'(gnt), 32'd0);
      check("done_low_idle", 32'(busy), 32'd0);
    end
    doneMode = M_RELEASE;
    waitGnt("done_release_grant", 20);
    doneMode = M_STUCK;
    repeat (int'(DONE_TO) + 2) tick();
    check("simul_err_before", 32'(timeout_err), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("simul_set_wins", 32'(timeout_err), 32'd1);

    // Reset asserted mid-transfer in DONE_WAIT.
    doneMode = M_RELEASE;
    tick();
    tick();
    doneMode = M_NORMAL;
    dropDly = 1;
    lowLen = 30;
    req_data = $urandom;
    pushGrants(4'b0010, 1);
    req = 4'b0010;
    waitGnt("midreset_grant", 20);
    repeat (5) tick();
    check("midreset_busy", 32'(busy), 32'd1);
    #2 sys_rst_l = 1'b0;
    #1 checkResetOutputs("async_reset");
    mLast = 3;
    tick();
    tick();
    sys_rst_l = 1'b1;
    req_data = $urandom;
    pushGrants(4'b1000, 1);
    req = 4'b1000;
    waitIdle("after_reset_req3", 200);

    // Randomized request batches.
    repeat (40) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("rand_err_clr", 32'(timeout_err), 32'd0);
      mask = 4'($urandom_range(1, 15));
      req_data = $urandom;
      expErr = ($urandom_range(0, 5) == 0);
      doneMode = expErr ? M_ACKTO : M_NORMAL;
      dropDly = $urandom_range(0, 2);
      lowLen = $urandom_range(2, 12);
      pushGrants(mask, $countones(mask));
      req = mask;
      waitIdle("random_batch", 400);
      check("rand_err", 32'(timeout_err), 32'(expErr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
